// File: rtl/cp0_except_unit.sv
// CP0 register file plus exception detection/commit for the MEM stage.
// Combinational exception code, single-edge commit; a stalled pipeline holds the code without committing.
module cp0_except_unit #(
  parameter logic [31:0] PRID = 32'h0000_4220
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cp0_we,
  input  logic [4:0]  cp0_waddr,
  input  logic [31:0] cp0_wdata,
  input  logic [4:0]  cp0_raddr,
  output logic [31:0] cp0_rdata,
  input  logic [5:0]  int_i,
  input  logic        mem_valid,
  input  logic [31:0] mem_pc,
  input  logic        mem_in_delayslot,
  input  logic        mem_syscall,
  input  logic        mem_ri,
  input  logic        mem_ov,
  input  logic        mem_trap,
  input  logic        mem_eret,
  input  logic        mem_stall,
  output logic [31:0] mem_excepttype,
  output logic [31:0] epc_o,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic        timer_int_o
);

  localparam logic [4:0] A_BADVADDR = 5'd8;
  localparam logic [4:0] A_COUNT    = 5'd9;
  localparam logic [4:0] A_COMPARE  = 5'd11;
  localparam logic [4:0] A_STATUS   = 5'd12;
  localparam logic [4:0] A_CAUSE    = 5'd13;
  localparam logic [4:0] A_EPC      = 5'd14;
  localparam logic [4:0] A_PRID     = 5'd15;

  logic [31:0] count;
  logic        cnt_tog;
  logic [31:0] compare;
  logic [7:0]  im;
  logic        exl;
  logic        ie;
  logic        bd;
  logic [7:0]  ip;
  logic [4:0]  exccode;
  logic [31:0] epc;
  logic        timer_int;

  logic wr_count, wr_compare, wr_status, wr_cause, wr_epc;
  assign wr_count   = cp0_we && (cp0_waddr == A_COUNT);
  assign wr_compare = cp0_we && (cp0_waddr == A_COMPARE);
  assign wr_status  = cp0_we && (cp0_waddr == A_STATUS);
  assign wr_cause   = cp0_we && (cp0_waddr == A_CAUSE);
  assign wr_epc     = cp0_we && (cp0_waddr == A_EPC);

  logic [31:0] status_reg, cause_reg, status_wv, cause_wv;
  assign status_reg = {16'b0, im, 6'b0, exl, ie};
  assign cause_reg  = {bd, 15'b0, ip, 1'b0, exccode, 2'b0};
  // Values the register would hold after the pending MTC0, for read bypass.
  assign status_wv  = cp0_wdata & 32'h0000_FF03;
  assign cause_wv   = {cause_reg[31:10], cp0_wdata[9:8], cause_reg[7:0]};

  assign status_o    = status_reg;
  assign cause_o     = cause_reg;
  assign timer_int_o = timer_int;
  assign epc_o       = wr_epc ? cp0_wdata : epc;

  logic bypass;
  assign bypass = cp0_we && (cp0_waddr == cp0_raddr);

  always_comb begin
    cp0_rdata = 32'b0;
    case (cp0_raddr)
      A_BADVADDR: cp0_rdata = 32'b0;
      A_COUNT:    cp0_rdata = bypass ? cp0_wdata : count;
      A_COMPARE:  cp0_rdata = bypass ? cp0_wdata : compare;
      A_STATUS:   cp0_rdata = bypass ? status_wv : status_reg;
      A_CAUSE:    cp0_rdata = bypass ? cause_wv  : cause_reg;
      A_EPC:      cp0_rdata = bypass ? cp0_wdata : epc;
      A_PRID:     cp0_rdata = PRID;
      default:    cp0_rdata = 32'b0;
    endcase
  end

  logic [7:0] pending;
  logic       int_req;
  logic [3:0] int_code;
  logic [4:0] commit_code;
  assign pending = ip & im;
  assign int_req = ie && !exl && (pending != 8'b0);

  always_comb begin
    int_code       = 4'd0;
    mem_excepttype = 32'b0;
    commit_code    = 5'd0;
    // Downward scan so the lowest set pending bit wins.
    for (int i = 7; i >= 0; i--) begin
      if (pending[i]) int_code = 4'(i + 1);
    end
    if (reset || !mem_valid) begin
      mem_excepttype = 32'b0;
    end else if (int_req) begin
      mem_excepttype = {28'b0, int_code};
      commit_code    = 5'd0;
    end else if (mem_ri) begin
      mem_excepttype = 32'h0000_000a;
      commit_code    = 5'd10;
    end else if (mem_ov) begin
      mem_excepttype = 32'h0000_000b;
      commit_code    = 5'd12;
    end else if (mem_syscall) begin
      mem_excepttype = 32'h0000_0009;
      commit_code    = 5'd8;
    end else if (mem_trap) begin
      mem_excepttype = 32'h0000_000c;
      commit_code    = 5'd13;
    end else if (mem_eret) begin
      mem_excepttype = 32'h0000_000d;
    end
  end

  logic commit, commit_eret;
  assign commit      = (mem_excepttype != 32'b0) && !mem_stall;
  assign commit_eret = (mem_excepttype == 32'h0000_000d);

  always_ff @(posedge clk) begin
    if (reset) begin
      count     <= 32'b0;
      cnt_tog   <= 1'b0;
      compare   <= 32'b0;
      im        <= 8'b0;
      exl       <= 1'b0;
      ie        <= 1'b0;
      bd        <= 1'b0;
      ip        <= 8'b0;
      exccode   <= 5'b0;
      epc       <= 32'b0;
      timer_int <= 1'b0;
    end else begin
      cnt_tog <= ~cnt_tog;
      if (cnt_tog) count <= count + 32'd1;
      if (wr_count) begin
        count   <= cp0_wdata;
        cnt_tog <= 1'b0;
      end

      if ((count == compare) && (compare != 32'b0)) timer_int <= 1'b1;
      if (wr_compare) begin
        compare   <= cp0_wdata;
        timer_int <= 1'b0;
      end

      ip[7:2] <= {int_i[5] | timer_int, int_i[4:0]};
      if (wr_cause) ip[1:0] <= cp0_wdata[9:8];

      if (wr_status) begin
        im  <= cp0_wdata[15:8];
        exl <= cp0_wdata[1];
        ie  <= cp0_wdata[0];
      end
      if (wr_epc) epc <= cp0_wdata;

      // Commit assignments come last so they override a same-cycle MTC0.
      if (commit) begin
        if (commit_eret) begin
          exl <= 1'b0;
        end else begin
          exl     <= 1'b1;
          epc     <= mem_in_delayslot ? (mem_pc - 32'd4) : mem_pc;
          bd      <= mem_in_delayslot;
          exccode <= commit_code;
        end
      end
    end
  end

endmodule

// File: tb/tb_cp0_except_unit.sv
// Self-checking bench for cp0_except_unit; expected exception codes flow through a scoreboard queue.
module tb_cp0_except_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cp0_we = 1'b0;
  logic [4:0]  cp0_waddr = 5'd0;
  logic [31:0] cp0_wdata = 32'd0;
  logic [4:0]  cp0_raddr = 5'd0;
  logic [31:0] cp0_rdata;
  logic [5:0]  int_i = 6'd0;
  logic        mem_valid = 1'b0;
  logic [31:0] mem_pc = 32'd0;
  logic        mem_in_delayslot = 1'b0;
  logic        mem_syscall = 1'b0, mem_ri = 1'b0, mem_ov = 1'b0, mem_trap = 1'b0, mem_eret = 1'b0;
  logic        mem_stall = 1'b0;
  logic [31:0] mem_excepttype, epc_o, status_o, cause_o;
  logic        timer_int_o;

  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp;

  cp0_except_unit dut (
    .clk(clk), .reset(reset),
    .cp0_we(cp0_we), .cp0_waddr(cp0_waddr), .cp0_wdata(cp0_wdata),
    .cp0_raddr(cp0_raddr), .cp0_rdata(cp0_rdata),
    .int_i(int_i),
    .mem_valid(mem_valid), .mem_pc(mem_pc), .mem_in_delayslot(mem_in_delayslot),
    .mem_syscall(mem_syscall), .mem_ri(mem_ri), .mem_ov(mem_ov),
    .mem_trap(mem_trap), .mem_eret(mem_eret), .mem_stall(mem_stall),
    .mem_excepttype(mem_excepttype), .epc_o(epc_o),
    .status_o(status_o), .cause_o(cause_o), .timer_int_o(timer_int_o)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    cp0_we = 1'b1; cp0_waddr = a; cp0_wdata = d;
    tick();
    cp0_we = 1'b0;
  endtask

  task automatic clear_mem;
    mem_valid = 1'b0; mem_ri = 1'b0; mem_syscall = 1'b0; mem_ov = 1'b0;
    mem_trap = 1'b0; mem_eret = 1'b0; mem_stall = 1'b0; mem_in_delayslot = 1'b0;
  endtask

  task automatic test_reset;
    logic [4:0] zero_addrs[7];
    zero_addrs = '{5'd8, 5'd11, 5'd12, 5'd13, 5'd14, 5'd3, 5'd31};
    reset = 1'b1; mem_valid = 1'b1; mem_ri = 1'b1;
    tick(); tick();
    @(negedge clk);
    n_checks++;
    if (mem_excepttype !== 32'h0) begin n_fail++; $display("FAIL reset_code got %h want 0", mem_excepttype); end
    n_checks++;
    if (timer_int_o !== 1'b0) begin n_fail++; $display("FAIL reset_timer got %b want 0", timer_int_o); end
    clear_mem();
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (10) tick();
    cp0_raddr = 5'd9;
    @(negedge clk);
    n_checks++;
    if (cp0_rdata !== 32'd5) begin n_fail++; $display("FAIL reset_count got %0d want 5", cp0_rdata); end
    for (int i = 0; i < 7; i++) begin
      cp0_raddr = zero_addrs[i];
      @(negedge clk);
      n_checks++;
      if (cp0_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_reg%0d got %h want 0", zero_addrs[i], cp0_rdata); end
    end
    cp0_raddr = 5'd15;
    @(negedge clk);
    n_checks++;
    if (cp0_rdata !== 32'h0000_4220) begin n_fail++; $display("FAIL prid got %h want 00004220", cp0_rdata); end
  endtask

  task automatic test_interrupt;
    @(posedge clk); #1;
    int_i = 6'b100000; mem_valid = 1'b1; mem_pc = 32'h100;
    cp0_we = 1'b1; cp0_waddr = 5'd12; cp0_wdata = 32'h0000_8001;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h8);
    @(negedge clk);
    exp = exp_q.pop_front();
    n_checks++;
    if (mem_excepttype !== exp) begin n_fail++; $display("FAIL int_cycle1 got %h want %h", mem_excepttype, exp); end
    tick();
    cp0_we = 1'b0;
    @(negedge clk);
    exp = exp_q.pop_front();
    n_checks++;
    if (mem_excepttype !== exp) begin n_fail++; $display("FAIL int_cycle2 got %h want %h", mem_excepttype, exp); end
    tick();
    @(negedge clk);
    n_checks++;
    if (epc_o !== 32'h100) begin n_fail++; $display("FAIL int_epc got %h want 00000100", epc_o); end
    n_checks++;
    if (status_o !== 32'h0000_8003) begin n_fail++; $display("FAIL int_status got %h want 00008003", status_o); end
    n_checks++;
    if (cause_o !== 32'h0000_8000) begin n_fail++; $display("FAIL int_cause got %h want 00008000", cause_o); end
    n_checks++;
    if (mem_excepttype !== 32'h0) begin n_fail++; $display("FAIL int_exl_mask got %h want 0", mem_excepttype); end
    @(posedge clk); #1;
    clear_mem(); int_i = 6'd0;
    tick();
  endtask

  task automatic test_ri_delayslot;
    mtc0(5'd12, 32'h0);
    mem_valid = 1'b1; mem_ri = 1'b1; mem_syscall = 1'b1; mem_in_delayslot = 1'b1; mem_pc = 32'h204;
    exp_q.push_back(32'ha);
    @(negedge clk);
    exp = exp_q.pop_front();
    n_checks++;
    if (mem_excepttype !== exp) begin n_fail++; $display("FAIL ri_code got %h want %h", mem_excepttype, exp); end
    tick();
    clear_mem();
    @(negedge clk);
    n_checks++;
    if (epc_o !== 32'h200) begin n_fail++; $display("FAIL ri_epc got %h want 00000200", epc_o); end
    n_checks++;
    if (cause_o !== 32'h8000_0028) begin n_fail++; $display("FAIL ri_cause got %h want 80000028", cause_o); end
    n_checks++;
    if (status_o !== 32'h0000_0002) begin n_fail++; $display("FAIL ri_status got %h want 00000002", status_o); end
  endtask

  task automatic test_stall;
    @(posedge clk); #1;
    mem_valid = 1'b1; mem_ri = 1'b1; mem_syscall = 1'b1; mem_in_delayslot = 1'b1;
    mem_pc = 32'h404; mem_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(32'ha);
      @(negedge clk);
      exp = exp_q.pop_front();
      n_checks++;
      if (mem_excepttype !== exp) begin n_fail++; $display("FAIL stall_code%0d got %h want %h", i, mem_excepttype, exp); end
      n_checks++;
      if (epc_o !== 32'h200) begin n_fail++; $display("FAIL stall_epc%0d got %h want 00000200", i, epc_o); end
      tick();
    end
    mem_stall = 1'b0;
    tick();
    clear_mem();
    @(negedge clk);
    n_checks++;
    if (epc_o !== 32'h400) begin n_fail++; $display("FAIL stall_release_epc got %h want 00000400", epc_o); end
    n_checks++;
    if (cause_o !== 32'h8000_0028) begin n_fail++; $display("FAIL stall_release_cause got %h want 80000028", cause_o); end
  endtask

  task automatic test_timer;
    bit found = 1'b0;
    @(posedge clk); #1;
    mtc0(5'd9, 32'd0);
    mtc0(5'd11, 32'd20);
    mtc0(5'd12, 32'h0000_8001);
    cp0_raddr = 5'd9;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (cp0_rdata == 32'd20) found = 1'b1;
    end
    n_checks++;
    if (!found) begin
      n_fail++; $display("FAIL timer_count_reach got %0d want 20 within budget", cp0_rdata);
    end else begin
      n_checks++;
      if (timer_int_o !== 1'b0) begin n_fail++; $display("FAIL timer_early got %b want 0", timer_int_o); end
      @(posedge clk); #1;
      mem_valid = 1'b1; mem_stall = 1'b1;
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h8);
      @(negedge clk);
      n_checks++;
      if (timer_int_o !== 1'b1) begin n_fail++; $display("FAIL timer_set got %b want 1", timer_int_o); end
      exp = exp_q.pop_front();
      n_checks++;
      if (mem_excepttype !== exp) begin n_fail++; $display("FAIL timer_code_pre got %h want %h", mem_excepttype, exp); end
      tick();
      @(negedge clk);
      exp = exp_q.pop_front();
      n_checks++;
      if (mem_excepttype !== exp) begin n_fail++; $display("FAIL timer_code got %h want %h", mem_excepttype, exp); end
      @(posedge clk); #1;
      mtc0(5'd11, 32'd40);
      @(negedge clk);
      n_checks++;
      if (timer_int_o !== 1'b0) begin n_fail++; $display("FAIL timer_clear got %b want 0", timer_int_o); end
    end
    @(posedge clk); #1;
    clear_mem();
    mtc0(5'd12, 32'h0);
  endtask

  task automatic test_same_cycle;
    tick();
    cp0_we = 1'b1; cp0_waddr = 5'd13; cp0_wdata = 32'hFFFF_FFFF;
    mem_valid = 1'b1; mem_syscall = 1'b1; mem_pc = 32'h500;
    exp_q.push_back(32'h9);
    @(negedge clk);
    exp = exp_q.pop_front();
    n_checks++;
    if (mem_excepttype !== exp) begin n_fail++; $display("FAIL same_code got %h want %h", mem_excepttype, exp); end
    tick();
    cp0_we = 1'b0;
    clear_mem();
    @(negedge clk);
    n_checks++;
    if (cause_o !== 32'h0000_0320) begin n_fail++; $display("FAIL same_cause got %h want 00000320", cause_o); end
    n_checks++;
    if (epc_o !== 32'h500) begin n_fail++; $display("FAIL same_epc got %h want 00000500", epc_o); end
    @(posedge clk); #1;
    mtc0(5'd13, 32'h0);
  endtask

  task automatic test_eret;
    mtc0(5'd12, 32'h0000_0002);
    cp0_we = 1'b1; cp0_waddr = 5'd14; cp0_wdata = 32'h300; cp0_raddr = 5'd14;
    mem_valid = 1'b1; mem_eret = 1'b1;
    exp_q.push_back(32'hd);
    @(negedge clk);
    exp = exp_q.pop_front();
    n_checks++;
    if (mem_excepttype !== exp) begin n_fail++; $display("FAIL eret_code got %h want %h", mem_excepttype, exp); end
    n_checks++;
    if (epc_o !== 32'h300) begin n_fail++; $display("FAIL eret_epc_bypass got %h want 00000300", epc_o); end
    n_checks++;
    if (cp0_rdata !== 32'h300) begin n_fail++; $display("FAIL eret_rdata_bypass got %h want 00000300", cp0_rdata); end
    tick();
    cp0_we = 1'b0;
    clear_mem();
    @(negedge clk);
    n_checks++;
    if (status_o !== 32'h0) begin n_fail++; $display("FAIL eret_status got %h want 0", status_o); end
    n_checks++;
    if (epc_o !== 32'h300) begin n_fail++; $display("FAIL eret_epc got %h want 00000300", epc_o); end
  endtask

  task automatic test_reset_mid;
    @(posedge clk); #1;
    reset = 1'b1; mem_valid = 1'b1; mem_ri = 1'b1; mem_pc = 32'h600;
    @(negedge clk);
    n_checks++;
    if (mem_excepttype !== 32'h0) begin n_fail++; $display("FAIL mid_reset_code got %h want 0", mem_excepttype); end
    tick();
    reset = 1'b0;
    clear_mem();
    @(negedge clk);
    n_checks++;
    if (epc_o !== 32'h0) begin n_fail++; $display("FAIL mid_reset_epc got %h want 0", epc_o); end
    n_checks++;
    if (cause_o !== 32'h0) begin n_fail++; $display("FAIL mid_reset_cause got %h want 0", cause_o); end
  endtask

  initial begin
    test_reset();
    test_interrupt();
    test_ri_delayslot();
    test_stall();
    test_timer();
    test_same_cycle();
    test_eret();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
